// File: rtl/mymem_pkg.sv
// Shared definitions for the scratchpad command sequencer.
// Contents: default address/data widths, command funct encodings and the
// sequencer state enum. Imported by mymem_seq_ctrl and mymem_burst_issuer.
package mymem_pkg;

  localparam int unsigned ADDR_W_DEF = 10;
  localparam int unsigned DATA_W_DEF = 64;

  localparam logic [1:0] FUNCT_WRITE = 2'd0;
  localparam logic [1:0] FUNCT_READ  = 2'd1;
  localparam logic [1:0] FUNCT_SUM   = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD_REQ,
    S_RD_WAIT,
    S_SUM,
    S_RESP
  } state_t;

endpackage

// File: rtl/mymem_burst_issuer.sv
// Burst bookkeeping for multi-word memory operations.
// Tracks how many requests have been issued and how many read beats have
// come back, generates the wrapping word address of the next request and
// flags the final read beat.
// Ports:
//   clock, reset   rising-edge clock, synchronous active-high reset
//   start          load base/len; the first request (base+0) is issued by
//                  the caller on the same edge
//   base, len      burst base address and word count
//   active         burst in progress (counters advance only while high)
//   rd_valid       read beat from memory
//   issue_next     another request is due next cycle
//   addr_next      address for that request (base+i modulo 2^ADDR_W)
//   rcv_fire       current read beat belongs to this burst
//   rcv_last       current read beat is the final one
module mymem_burst_issuer import mymem_pkg::*; #(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned LEN_W  = ADDR_W + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [LEN_W-1:0]  len,
  input  logic              active,
  input  logic              rd_valid,
  output logic              issue_next,
  output logic [ADDR_W-1:0] addr_next,
  output logic              rcv_fire,
  output logic              rcv_last
);

  logic [LEN_W-1:0]  issue_cnt;
  logic [LEN_W-1:0]  rcv_cnt;
  logic [LEN_W-1:0]  len_q;
  logic [ADDR_W-1:0] base_q;
  logic              done;

  always_ff @(posedge clock) begin
    if (reset) begin
      issue_cnt <= '0;
      rcv_cnt   <= '0;
      len_q     <= '0;
      base_q    <= '0;
    end else if (start) begin
      // issue count starts at 1: the first request leaves on the start edge
      issue_cnt <= LEN_W'(1);
      rcv_cnt   <= '0;
      len_q     <= len;
      base_q    <= base;
    end else if (active) begin
      if (issue_next) issue_cnt <= issue_cnt + LEN_W'(1);
      if (rcv_fire)   rcv_cnt   <= rcv_cnt + LEN_W'(1);
    end
  end

  assign done       = (rcv_cnt == len_q);
  assign issue_next = active && (issue_cnt < len_q);
  // issue_cnt < len_q <= 2^ADDR_W whenever this is used, so the slice is exact
  assign addr_next  = base_q + issue_cnt[ADDR_W-1:0];
  assign rcv_fire   = active && rd_valid && !done;
  assign rcv_last   = rcv_fire && ((rcv_cnt + LEN_W'(1)) == len_q);

endmodule

// File: rtl/mymem_seq_ctrl.sv
// Command sequencer in front of the single-port scratchpad memory.
// Accepts WRITE / READ / SUM commands, drives the memory request port,
// collects 1-cycle-latency read data and returns READ/SUM results on a
// valid/ready response channel. funct 3 is consumed silently.
// Ports:
//   clock, reset                 rising-edge clock, synchronous active-high reset
//   cmd_valid/cmd_ready          command handshake
//   cmd_funct/rd/addr/len/data   command fields
//   resp_valid/resp_ready        response handshake
//   resp_rd/resp_data            echoed tag and result
//   mem_rqvalid/wren/addr/wrdata memory request port
//   mem_rdvalid/rddata           memory read return
//   busy                         sequencer not idle
module mymem_seq_ctrl import mymem_pkg::*; #(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned LEN_W  = ADDR_W + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_funct,
  input  logic [4:0]        cmd_rd,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [4:0]        resp_rd,
  output logic [DATA_W-1:0] resp_data,
  output logic              mem_rqvalid,
  output logic              mem_wren,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wrdata,
  input  logic              mem_rdvalid,
  input  logic [DATA_W-1:0] mem_rddata,
  output logic              busy
);

  state_t            state;
  logic [DATA_W-1:0] acc;
  logic              burst_start;
  logic              issue_next;
  logic [ADDR_W-1:0] addr_next;
  logic              rcv_fire;
  logic              rcv_last;

  // Handshake/status outputs are pure decodes of the registered state.
  assign cmd_ready  = (state == S_IDLE);
  assign resp_valid = (state == S_RESP);
  assign mem_wren   = (state == S_WR);
  assign busy       = (state != S_IDLE);

  assign burst_start = cmd_valid && (state == S_IDLE) && (cmd_funct == FUNCT_SUM);

  mymem_burst_issuer #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_issuer (
    .clock      (clock),
    .reset      (reset),
    .start      (burst_start),
    .base       (cmd_addr),
    .len        (cmd_len),
    .active     (state == S_SUM),
    .rd_valid   (mem_rdvalid),
    .issue_next (issue_next),
    .addr_next  (addr_next),
    .rcv_fire   (rcv_fire),
    .rcv_last   (rcv_last)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      mem_rqvalid <= 1'b0;
      mem_addr    <= '0;
      mem_wrdata  <= '0;
      resp_rd     <= '0;
      resp_data   <= '0;
      acc         <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            resp_rd    <= cmd_rd;
            mem_addr   <= cmd_addr;
            mem_wrdata <= cmd_data;
            case (cmd_funct)
              FUNCT_WRITE: state <= S_WR;
              FUNCT_READ: begin
                state       <= S_RD_REQ;
                mem_rqvalid <= 1'b1;
              end
              FUNCT_SUM: begin
                acc <= '0;
                if (cmd_len != '0) begin
                  state       <= S_SUM;
                  mem_rqvalid <= 1'b1;
                end else begin
                  state     <= S_RESP;
                  resp_data <= '0;
                end
              end
              default: ;
            endcase
          end
        end

        S_WR: state <= S_IDLE;

        S_RD_REQ: begin
          mem_rqvalid <= 1'b0;
          state       <= S_RD_WAIT;
        end

        S_RD_WAIT: begin
          if (mem_rdvalid) begin
            resp_data <= mem_rddata;
            state     <= S_RESP;
          end
        end

        S_SUM: begin
          mem_rqvalid <= issue_next;
          if (issue_next) mem_addr <= addr_next;
          if (rcv_fire) acc <= acc + mem_rddata;
          // final beat folds straight into the response so RESP starts next cycle
          if (rcv_last) begin
            resp_data <= acc + mem_rddata;
            state     <= S_RESP;
          end
        end

        S_RESP: begin
          if (resp_ready) state <= S_IDLE;
        end

        default: begin
          state       <= S_IDLE;
          mem_rqvalid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mymem_seq_ctrl.sv
// Self-checking bench for mymem_seq_ctrl: a 1024x64 memory with 1-cycle
// read latency sits on the request port, and a word-array reference model
// predicts every response value and latency.
module tb_mymem_seq_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_funct = '0;
  logic [4:0]  cmd_rd = '0;
  logic [9:0]  cmd_addr = '0;
  logic [10:0] cmd_len = '0;
  logic [63:0] cmd_data = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [4:0]  resp_rd;
  logic [63:0] resp_data;
  logic        mem_rqvalid;
  logic        mem_wren;
  logic [9:0]  mem_addr;
  logic [63:0] mem_wrdata;
  logic        mem_rdvalid = 1'b0;
  logic [63:0] mem_rddata = '0;
  logic        busy;

  int unsigned tests = 0;
  int unsigned failed = 0;

  logic [63:0] mem     [1024];
  logic [63:0] ref_mem [1024];
  logic [9:0]  addr_q  [$];
  bit          both_err = 1'b0;

  always #5 clock = ~clock;

  mymem_seq_ctrl #(
    .ADDR_W (10),
    .DATA_W (64),
    .LEN_W  (11)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_funct   (cmd_funct),
    .cmd_rd      (cmd_rd),
    .cmd_addr    (cmd_addr),
    .cmd_len     (cmd_len),
    .cmd_data    (cmd_data),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_rd     (resp_rd),
    .resp_data   (resp_data),
    .mem_rqvalid (mem_rqvalid),
    .mem_wren    (mem_wren),
    .mem_addr    (mem_addr),
    .mem_wrdata  (mem_wrdata),
    .mem_rdvalid (mem_rdvalid),
    .mem_rddata  (mem_rddata),
    .busy        (busy)
  );

  // Scratchpad memory: 1-cycle read latency, write on wren.
  always @(posedge clock) begin
    mem_rdvalid <= mem_rqvalid;
    if (mem_rqvalid) mem_rddata <= mem[mem_addr];
    if (mem_wren) mem[mem_addr] <= mem_wrdata;
    if (mem_wren && mem_rqvalid) both_err <= 1'b1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_sum(input int unsigned a, input int unsigned l);
    logic [63:0] s = '0;
    for (int unsigned i = 0; i < l; i++) s += ref_mem[(a + i) % 1024];
    return s;
  endfunction

  // Present one command; returns at the negedge of cycle T+1.
  task automatic send_cmd(input logic [1:0] f, input logic [4:0] rd, input logic [9:0] a,
                          input logic [10:0] l, input logic [63:0] d);
    int unsigned n = 0;
    while (!cmd_ready && n < 50) begin
      step();
      n++;
    end
    check("cmd_ready_before_cmd", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_funct = f;
    cmd_rd    = rd;
    cmd_addr  = a;
    cmd_len   = l;
    cmd_data  = d;
    step();
    cmd_valid = 1'b0;
  endtask

  // Waits for resp_valid; off is the cycle offset from the accept cycle T.
  task automatic wait_resp(input int unsigned max, output int unsigned off, output int unsigned nrq);
    off = 1;
    nrq = 0;
    addr_q.delete();
    forever begin
      if (mem_rqvalid) begin
        nrq++;
        addr_q.push_back(mem_addr);
      end
      if (resp_valid || off >= max) break;
      step();
      off++;
    end
    check("resp_timeout", resp_valid, 1);
  endtask

  task automatic consume(input logic [4:0] rd, input logic [63:0] d, input string tag,
                         input int unsigned dly);
    for (int unsigned i = 0; i < dly; i++) step();
    check({tag, "_rd"}, resp_rd, rd);
    check({tag, "_data"}, resp_data, d);
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    check({tag, "_idle_after"}, cmd_ready, 1);
  endtask

  task automatic do_write(input logic [9:0] a, input logic [63:0] d);
    send_cmd(2'd0, 5'($urandom), a, '0, d);
    ref_mem[a] = d;
    step();
  endtask

  task automatic do_read(input logic [4:0] rd, input logic [9:0] a, input string tag,
                         input int unsigned dly);
    int unsigned off, nrq;
    send_cmd(2'd1, rd, a, '0, 64'($urandom));
    wait_resp(10, off, nrq);
    check({tag, "_latency"}, 64'(off), 3);
    consume(rd, ref_mem[a], tag, dly);
  endtask

  task automatic do_sum(input logic [4:0] rd, input logic [9:0] a, input int unsigned l,
                        input string tag, input int unsigned dly);
    int unsigned off, nrq, exp_off;
    exp_off = (l == 0) ? 1 : l + 2;
    send_cmd(2'd2, rd, a, 11'(l), 64'($urandom));
    wait_resp(l + 10, off, nrq);
    check({tag, "_latency"}, 64'(off), 64'(exp_off));
    check({tag, "_nreq"}, 64'(nrq), 64'(l));
    consume(rd, ref_sum(a, l), tag, dly);
  endtask

  initial begin
    int unsigned off, nrq;
    logic [63:0] d;
    logic [9:0]  a;
    logic [4:0]  rd;

    // Reset state
    repeat (3) @(negedge clock);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_rqvalid", mem_rqvalid, 0);
    check("rst_wren", mem_wren, 0);
    check("rst_busy", busy, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wrdata", mem_wrdata, 0);
    check("rst_resp_rd", resp_rd, 0);
    check("rst_resp_data", resp_data, 0);
    reset = 1'b0;
    step();

    // Fill every word so reads never see uninitialised data
    for (int unsigned i = 0; i < 1024; i++) do_write(10'(i), {$urandom, $urandom});

    // Directed WRITE then READ
    send_cmd(2'd0, 5'd3, 10'd5, '0, 64'hDEADBEEF_00000001);
    check("wr_wren", mem_wren, 1);
    check("wr_rqvalid", mem_rqvalid, 0);
    check("wr_addr", mem_addr, 5);
    check("wr_data", mem_wrdata, 64'hDEADBEEF_00000001);
    check("wr_busy", busy, 1);
    ref_mem[5] = 64'hDEADBEEF_00000001;
    step();
    check("wr_wren_done", mem_wren, 0);
    check("wr_cmd_ready_t2", cmd_ready, 1);
    do_read(5'd7, 10'd5, "read5", 0);

    // SUM of 1..4
    for (int unsigned i = 0; i < 4; i++) do_write(10'(i), 64'(i + 1));
    do_sum(5'd3, 10'd0, 4, "sum4", 0);
    check("sum4_value", ref_sum(0, 4), 64'd10);

    // Wrapping SUM across the top word
    do_write(10'd1023, '1);
    do_write(10'd0, 64'd2);
    do_sum(5'd9, 10'd1023, 2, "sumwrap", 0);
    check("sumwrap_naddr", 64'(addr_q.size()), 2);
    if (addr_q.size() == 2) begin
      check("sumwrap_addr0", addr_q[0], 1023);
      check("sumwrap_addr1", addr_q[1], 0);
    end

    // Zero-length SUM
    do_sum(5'd4, 10'd100, 0, "sum0", 0);

    // Reserved funct: no activity, stays ready
    send_cmd(2'd3, 5'd5, 10'd10, '0, '0);
    for (int unsigned i = 0; i < 4; i++) begin
      check("rsvd_quiet", {mem_rqvalid, mem_wren, resp_valid, cmd_ready, busy}, 5'b00010);
      step();
    end

    // Response backpressure
    send_cmd(2'd1, 5'd12, 10'd77, '0, '0);
    wait_resp(10, off, nrq);
    for (int unsigned i = 0; i < 10; i++) begin
      check("bp_hold", {resp_valid, cmd_ready, resp_rd}, {1'b1, 1'b0, 5'd12});
      check("bp_data", resp_data, ref_mem[77]);
      step();
    end
    consume(5'd12, ref_mem[77], "bp", 0);

    // Reset in the middle of an 8-word SUM, after 3 issues
    send_cmd(2'd2, 5'd1, 10'd500, 11'd8, '0);
    step();
    step();
    check("mid_rqvalid", mem_rqvalid, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_rst_state", {busy, resp_valid, cmd_ready}, 3'b001);
    for (int unsigned i = 0; i < 5; i++) begin
      check("mid_rst_quiet", {mem_rqvalid, busy, resp_valid}, 3'b000);
      step();
    end
    do_read(5'd2, 10'd501, "read_after_rst", 0);

    // Full-depth SUM: every word exactly once
    do_sum(5'd6, 10'($urandom_range(0, 1023)), 1024, "sum_full", 0);

    // Randomized commands against the reference model
    for (int unsigned it = 0; it < 60; it++) begin
      a  = 10'($urandom);
      rd = 5'($urandom);
      d  = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0: do_write(a, d);
        1: do_read(rd, a, "rnd_read", $urandom_range(0, 3));
        2: do_sum(rd, a, $urandom_range(0, 24), "rnd_sum", $urandom_range(0, 3));
        default: begin
          send_cmd(2'd3, rd, a, '0, d);
          check("rnd_rsvd", {cmd_ready, busy, mem_rqvalid, mem_wren}, 4'b1000);
        end
      endcase
    end

    check("wren_rqvalid_exclusive", 64'(both_err), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/mymem_seq_ctrl.md
Name: mymem_seq_ctrl

Overview:
Command sequencer that sits directly upstream of the 1024x64 scratchpad memory in the RoCC example accelerator.
- Accepts decoded RoCC-style commands over a valid/ready handshake.
- Drives the memory's single request port: request valid, write enable, address, write data.
- Consumes the memory's 1-cycle-latency read data.
- Returns results over a valid/ready response channel toward the core interface.
- Supports single write, single read, and a multi-word SUM over a wrapping address range.

Parameters:
ADDR_W, 10, memory word-address width (depth 2^ADDR_W)
DATA_W, 64, data/accumulator width
LEN_W, ADDR_W+1, length field width (0..2^ADDR_W words)

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when valid&&ready
cmd_funct  in  2  0=WRITE, 1=READ, 2=SUM, 3=reserved
cmd_rd  in  5  destination register tag, echoed on response
cmd_addr  in  ADDR_W  base word address
cmd_len  in  LEN_W  SUM word count
cmd_data  in  DATA_W  WRITE data
resp_valid  out  1  response available
resp_ready  in  1  response consumed when valid&&ready
resp_rd  out  5  echoed cmd_rd
resp_data  out  DATA_W  read value or sum
mem_rqvalid  out  1  memory read request
mem_wren  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wrdata  out  DATA_W  memory write data
mem_rdvalid  in  1  read data valid (one cycle after mem_rqvalid)
mem_rddata  in  DATA_W  read data
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values:
  - state=IDLE, cmd_ready=1, resp_valid=0, mem_rqvalid=0, mem_wren=0, busy=0.
  - mem_addr, mem_wrdata, resp_rd, resp_data, accumulator and counters all 0.
- All outputs are registered or decoded from registered state only; no combinational path from inputs to outputs.
- States: IDLE, WR, RD_REQ, RD_WAIT, SUM, RESP.
- IDLE:
  - cmd_ready=1.
  - On accept at cycle T, latch rd/addr/len/data, then branch on funct:
    - WRITE -> WR
    - READ -> RD_REQ
    - SUM with len>0 -> SUM
    - SUM with len==0 -> RESP with data 0
    - funct 3 -> stay IDLE; command is consumed silently with no memory access and no response.
- WR:
  - mem_wren=1, mem_rqvalid=0 for exactly one cycle (T+1).
  - Then IDLE; cmd_ready high again at T+2.
  - No response is generated.
- RD_REQ: mem_rqvalid=1 at T+1 -> RD_WAIT.
- RD_WAIT: capture mem_rddata when mem_rdvalid=1 (T+2) -> RESP; resp_valid=1 from T+3.
- SUM:
  - Issue side: mem_rqvalid=1 on consecutive cycles T+1..T+len.
    - Address = base+i modulo 2^ADDR_W, so it wraps past the top word.
  - Receive side: each cycle with mem_rdvalid=1 adds mem_rddata to the accumulator, modulo 2^DATA_W (overflow discarded).
  - An issue counter and a receive counter both count up to len.
  - Move to RESP the cycle after the receive count reaches len; resp_valid=1 at T+len+2.
  - len == 2^ADDR_W (1024) is legal: every word is summed exactly once.
- RESP:
  - resp_valid=1; resp_rd/resp_data held stable until resp_ready=1.
  - On handshake -> IDLE; cmd_ready=1 the next cycle.
  - No new command is accepted while a response is pending.
- mem_rdvalid is ignored outside RD_WAIT and SUM, and ignored in SUM once the receive count equals len.
- mem_wren and mem_rqvalid are never asserted in the same cycle.
- Reset mid-operation:
  - Outstanding requests are abandoned and any pending response is dropped.
  - Memory contents are untouched.
  - A late mem_rdvalid arriving the cycle after reset is ignored.

Decomposition:
- Shared package mymem_pkg holds:
  - funct encodings: FUNCT_WRITE=0, FUNCT_READ=1, FUNCT_SUM=2.
  - State enum.
  - ADDR_W and DATA_W defaults.
- One natural sub-module: mymem_burst_issuer. It owns the issue/receive counters, wrapping address generation and done flag, and is reusable for later burst ops.
- The accumulator and FSM stay in the top module.

Test Plan:
- WRITE addr 5 data 0xDEADBEEF_00000001, then READ addr 5, rd=7 -> resp_rd=7, resp_data=0xDEADBEEF00000001; resp_valid 3 cycles after READ accept.
- Preload words 0..3 with 1,2,3,4; SUM addr 0 len 4 -> resp_data=10; mem_rqvalid high 4 consecutive cycles; resp_valid at T+6.
- Preload word 1023=0xFFFFFFFFFFFFFFFF and word 0=2; SUM addr 1023 len 2 -> mem_addr sequence 1023,0; resp_data=1 (modulo wrap).
- SUM len 0 -> resp_valid at T+1, resp_data=0, no mem_rqvalid pulses. funct 3 -> no memory activity, no response, cmd_ready stays 1.
- Hold resp_ready=0 for 10 cycles after a READ -> resp_valid, resp_rd and resp_data stable; cmd_ready=0 throughout; IDLE the cycle after resp_ready=1.
- Assert reset mid-SUM (after 3 of 8 issues) -> next cycle: busy=0, resp_valid=0, cmd_ready=1, no further mem_rqvalid; a subsequent READ returns correct data.
